pio_uart_bridge: RTL and testbench

Sits on the far side of the Nios 8-bit bidirectional data PIO and connects the processor's software-timed byte bus to the wireless module's UART.
- Bytes the host drives onto the bus are buffered and serialised as 8N1.
- Bytes received from the module are buffered and driven back onto the bus when the host turns it around.
- Two small FIFOs decouple the slow, software-paced bus from the serial timing.

---
 rtl/pio_uart_bridge_pkg.sv | 42 ++++
 rtl/pio_uart_bridge_sync_fifo.sv | 75 +++++++
 rtl/pio_uart_bridge.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_pio_uart_bridge.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_uart_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pio_uart_bridge_pkg                                            |
// | Purpose  : Shared definitions for the PIO-to-UART bridge. Holds the FSM   |
// |            state encoding used by both serial engines, the bit-period     |
// |            derivation and a width helper for counters and pointers.       |
// | Ports    : none (package)                                                 |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package pio_uart_bridge_pkg;

   // Common encoding for the transmit and receive state machines.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   // Number of bits needed to hold values 0..value-1 (never less than 1).
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      if (result == 0) begin
         result = 1;
      end
      return result;
   endfunction

   // Clock cycles per serial bit; integer division truncates.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pio_uart_bridge_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bridge_sync_fifo                                               |
// | Purpose  : Single-clock show-ahead FIFO. Read and write pointers carry an |
// |            extra wrap bit to tell full from empty.                        |
// | Ports    : clk, reset_n  - clock, async active-low reset                  |
// |            push, din     - write strobe and data                          |
// |            pop           - remove head entry                              |
// |            dout          - current head (valid while !empty)              |
// |            full, empty   - registered occupancy flags                     |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module bridge_sync_fifo
   import pio_uart_bridge_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int c_aw = clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw:0]    r_wr_ptr;
   logic [c_aw:0]    r_rd_ptr;
   logic             r_full;
   logic             r_empty;

   logic             w_do_push;
   logic             w_do_pop;
   logic [c_aw:0]    w_wr_nx;
   logic [c_aw:0]    w_rd_nx;

   // A push into a full FIFO is still taken when the head leaves that cycle,
   // since the slot being written is the one being vacated.
   assign w_do_pop  = pop && !r_empty;
   assign w_do_push = push && (!r_full || w_do_pop);
   assign w_wr_nx   = r_wr_ptr + {{c_aw{1'b0}}, w_do_push};
   assign w_rd_nx   = r_rd_ptr + {{c_aw{1'b0}}, w_do_pop};

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[c_aw-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         r_wr_ptr <= w_wr_nx;
         r_rd_ptr <= w_rd_nx;
         r_empty  <= (w_wr_nx == w_rd_nx);
         r_full   <= (w_wr_nx[c_aw] != w_rd_nx[c_aw]) &&
                     (w_wr_nx[c_aw-1:0] == w_rd_nx[c_aw-1:0]);
      end
   end

   assign dout  = r_mem[r_rd_ptr[c_aw-1:0]];
   assign full  = r_full;
   assign empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/pio_uart_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pio_uart_bridge                                                |
// | Purpose  : Connects a software-paced 8-bit bidirectional PIO byte bus to  |
// |            an 8N1 UART, with a FIFO in each direction.                    |
// | Ports    : clk, reset_n  - clock, async active-low reset                  |
// |            bus_data      - shared byte bus (bridge drives while reading)  |
// |            bus_load      - host strobe, byte on bus_data to transmit      |
// |            bus_read      - host request, bridge drives RX head            |
// |            err_clr       - host strobe, clears sticky error flags         |
// |            tx_full       - TX FIFO full                                   |
// |            rx_avail      - RX FIFO not empty                              |
// |            rx_overrun    - sticky, RX byte dropped on full FIFO           |
// |            frame_err     - sticky, stop bit sampled low                   |
// |            uart_txd      - serial out, idles high                         |
// |            uart_rxd      - serial in, asynchronous                        |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module pio_uart_bridge
   import pio_uart_bridge_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   inout  wire  [7:0] bus_data,
   input  logic       bus_load,
   input  logic       bus_read,
   input  logic       err_clr,
   output logic       tx_full,
   output logic       rx_avail,
   output logic       rx_overrun,
   output logic       frame_err,
   output logic       uart_txd,
   input  logic       uart_rxd
);

   localparam int                 c_cpb      = clks_per_bit(CLK_HZ, BAUD);
   localparam int                 c_cnt_w    = clog2(c_cpb);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_cpb - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_mid  = c_cnt_w'(c_cpb / 2);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   // ---------------------------------------------------------------- sync
   // Bit order: [3]=uart_rxd, [2]=err_clr, [1]=bus_read, [0]=bus_load.
   // The serial line resets to its idle (high) level so no false start.
   logic [3:0] r_sync_m;
   logic [3:0] r_sync_s;
   logic [2:0] r_sync_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync_m <= 4'b1000;
         r_sync_s <= 4'b1000;
         r_sync_d <= 3'b000;
      end else begin
         r_sync_m <= {uart_rxd, err_clr, bus_read, bus_load};
         r_sync_s <= r_sync_m;
         r_sync_d <= r_sync_s[2:0];
      end
   end

   logic w_load_rise;
   logic w_read;
   logic w_read_fall;
   logic w_clr_rise;
   logic w_rxd;

   assign w_load_rise = r_sync_s[0] & ~r_sync_d[0];
   assign w_read      = r_sync_s[1];
   assign w_read_fall = ~r_sync_s[1] & r_sync_d[1];
   assign w_clr_rise  = r_sync_s[2] & ~r_sync_d[2];
   assign w_rxd       = r_sync_s[3];

   // ---------------------------------------------------------------- FIFOs
   logic [7:0] w_tx_head;
   logic       w_tx_full;
   logic       w_tx_empty;
   logic       w_tx_pop;
   logic [7:0] w_rx_head;
   logic       w_rx_full;
   logic       w_rx_empty;
   logic       w_rx_push;
   logic [7:0] r_rx_shift;

   bridge_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (w_load_rise),
      .pop     (w_tx_pop),
      .din     (bus_data),
      .dout    (w_tx_head),
      .full    (w_tx_full),
      .empty   (w_tx_empty)
   );

   bridge_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (w_rx_push),
      .pop     (w_read_fall),
      .din     (r_rx_shift),
      .dout    (w_rx_head),
      .full    (w_rx_full),
      .empty   (w_rx_empty)
   );

   // An empty FIFO reads back as zero rather than a stale entry.
   logic [7:0] w_rd_byte;
   assign w_rd_byte = w_rx_empty ? 8'h00 : w_rx_head;
   assign bus_data  = w_read ? w_rd_byte : 8'hzz;

   // ---------------------------------------------------------------- TX
   // uart_txd is registered and always holds the level of the current state,
   // so each state lasts exactly one bit period.
   uart_state_t        r_tx_state, w_tx_state_nx;
   logic [c_cnt_w-1:0] r_tx_cnt,   w_tx_cnt_nx;
   logic [2:0]         r_tx_bit,   w_tx_bit_nx;
   logic [7:0]         r_tx_shift, w_tx_shift_nx;
   logic               r_txd,      w_txd_nx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tx_state <= ST_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_txd      <= 1'b1;
      end else begin
         r_tx_state <= w_tx_state_nx;
         r_tx_cnt   <= w_tx_cnt_nx;
         r_tx_bit   <= w_tx_bit_nx;
         r_tx_shift <= w_tx_shift_nx;
         r_txd      <= w_txd_nx;
      end
   end

   always_comb begin
      w_tx_state_nx = r_tx_state;
      w_tx_cnt_nx   = r_tx_cnt + c_cnt_one;
      w_tx_bit_nx   = r_tx_bit;
      w_tx_shift_nx = r_tx_shift;
      w_txd_nx      = r_txd;
      w_tx_pop      = 1'b0;
      case (r_tx_state)
         ST_IDLE: begin
            w_tx_cnt_nx = '0;
            w_txd_nx    = 1'b1;
            if (!w_tx_empty) begin
               w_tx_pop      = 1'b1;
               w_tx_shift_nx = w_tx_head;
               w_tx_state_nx = ST_START;
               w_txd_nx      = 1'b0;
            end
         end
         ST_START: begin
            if (r_tx_cnt == c_cnt_last) begin
               w_tx_cnt_nx   = '0;
               w_tx_bit_nx   = '0;
               w_tx_state_nx = ST_DATA;
               w_txd_nx      = r_tx_shift[0];
            end
         end
         ST_DATA: begin
            if (r_tx_cnt == c_cnt_last) begin
               w_tx_cnt_nx = '0;
               if (r_tx_bit == 3'd7) begin
                  w_tx_state_nx = ST_STOP;
                  w_txd_nx      = 1'b1;
               end else begin
                  w_tx_bit_nx   = r_tx_bit + 3'd1;
                  w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                  w_txd_nx      = r_tx_shift[1];
               end
            end
         end
         ST_STOP: begin
            if (r_tx_cnt == c_cnt_last) begin
               w_tx_cnt_nx = '0;
               // Chain straight into the next start bit when data waits.
               if (!w_tx_empty) begin
                  w_tx_pop      = 1'b1;
                  w_tx_shift_nx = w_tx_head;
                  w_tx_state_nx = ST_START;
                  w_txd_nx      = 1'b0;
               end else begin
                  w_tx_state_nx = ST_IDLE;
                  w_txd_nx      = 1'b1;
               end
            end
         end
         default: begin
            w_tx_state_nx = ST_IDLE;
            w_txd_nx      = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------- RX
   // The start bit is confirmed at its midpoint; every later sample falls a
   // whole bit period after the previous one, i.e. mid-bit.
   uart_state_t        r_rx_state, w_rx_state_nx;
   logic [c_cnt_w-1:0] r_rx_cnt,   w_rx_cnt_nx;
   logic [2:0]         r_rx_bit,   w_rx_bit_nx;
   logic [7:0]         w_rx_shift_nx;
   logic               w_set_overrun;
   logic               w_set_ferr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_state <= ST_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_state <= w_rx_state_nx;
         r_rx_cnt   <= w_rx_cnt_nx;
         r_rx_bit   <= w_rx_bit_nx;
         r_rx_shift <= w_rx_shift_nx;
      end
   end

   always_comb begin
      w_rx_state_nx = r_rx_state;
      w_rx_cnt_nx   = r_rx_cnt + c_cnt_one;
      w_rx_bit_nx   = r_rx_bit;
      w_rx_shift_nx = r_rx_shift;
      w_rx_push     = 1'b0;
      w_set_overrun = 1'b0;
      w_set_ferr    = 1'b0;
      case (r_rx_state)
         ST_IDLE: begin
            w_rx_cnt_nx = '0;
            if (!w_rxd) begin
               w_rx_state_nx = ST_START;
            end
         end
         ST_START: begin
            if (r_rx_cnt == c_cnt_mid) begin
               w_rx_cnt_nx = '0;
               w_rx_bit_nx = '0;
               // A line that is high again by mid-start was a glitch.
               w_rx_state_nx = w_rxd ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (r_rx_cnt == c_cnt_last) begin
               w_rx_cnt_nx   = '0;
               w_rx_shift_nx = {w_rxd, r_rx_shift[7:1]};
               if (r_rx_bit == 3'd7) begin
                  w_rx_state_nx = ST_STOP;
               end else begin
                  w_rx_bit_nx = r_rx_bit + 3'd1;
               end
            end
         end
         ST_STOP: begin
            if (r_rx_cnt == c_cnt_last) begin
               w_rx_cnt_nx   = '0;
               w_rx_state_nx = ST_IDLE;
               if (!w_rxd) begin
                  w_set_ferr = 1'b1;
               end else if (w_rx_full) begin
                  w_set_overrun = 1'b1;
               end else begin
                  w_rx_push = 1'b1;
               end
            end
         end
         default: begin
            w_rx_state_nx = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- flags
   // A new error in the same cycle as a clear keeps the flag set.
   logic r_rx_overrun;
   logic r_frame_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_overrun <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         if (w_set_overrun) begin
            r_rx_overrun <= 1'b1;
         end else if (w_clr_rise) begin
            r_rx_overrun <= 1'b0;
         end
         if (w_set_ferr) begin
            r_frame_err <= 1'b1;
         end else if (w_clr_rise) begin
            r_frame_err <= 1'b0;
         end
      end
   end

   assign tx_full    = w_tx_full;
   assign rx_avail   = ~w_rx_empty;
   assign rx_overrun = r_rx_overrun;
   assign frame_err  = r_frame_err;
   assign uart_txd   = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_pio_uart_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pio_uart_bridge                                             |
// | Purpose  : Self-checking bench for pio_uart_bridge at 16 clocks per bit.  |
// |            A table of TX/RX byte pairs is applied in a loop; TX frames    |
// |            are checked cycle by cycle against a scoreboard queue, RX      |
// |            bytes against a second queue popped by host reads.            |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_pio_uart_bridge;

   localparam int CPB   = 16;
   localparam int FRAME = 10 * CPB;

   logic       clk       = 1'b0;
   logic       reset_n   = 1'b0;
   logic       bus_load  = 1'b0;
   logic       bus_read  = 1'b0;
   logic       err_clr   = 1'b0;
   logic       uart_rxd  = 1'b1;
   logic       tx_full;
   logic       rx_avail;
   logic       rx_overrun;
   logic       frame_err;
   logic       uart_txd;
   wire  [7:0] bus_data;
   logic [7:0] host_drv  = 8'h00;
   logic       host_oe   = 1'b0;

   assign bus_data = host_oe ? host_drv : 8'hzz;

   always #5 clk = ~clk;

   pio_uart_bridge #(.CLK_HZ(1600), .BAUD(100), .FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus_data   (bus_data),
      .bus_load   (bus_load),
      .bus_read   (bus_read),
      .err_clr    (err_clr),
      .tx_full    (tx_full),
      .rx_avail   (rx_avail),
      .rx_overrun (rx_overrun),
      .frame_err  (frame_err),
      .uart_txd   (uart_txd),
      .uart_rxd   (uart_rxd)
   );

   int         n_vec       = 0;
   int         n_err       = 0;
   int         cyc         = 0;
   logic [7:0] tx_exp [$];
   logic [7:0] rx_exp [$];
   logic       mon_busy    = 1'b0;
   logic       gap_chk     = 1'b0;
   logic       gap_valid   = 1'b0;
   int         last_start  = 0;
   int         frames_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check1(input string nm, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Host writes one byte; the expectation is queued as the stimulus goes out.
   task automatic host_load(input logic [7:0] b, input logic accept);
      if (accept) tx_exp.push_back(b);
      @(posedge clk);
      host_drv = b;
      host_oe  = 1'b1;
      @(posedge clk);
      bus_load = 1'b1;
      repeat (4) @(posedge clk);
      bus_load = 1'b0;
      repeat (2) @(posedge clk);
      host_oe  = 1'b0;
   endtask

   // Host read cycle; an empty scoreboard means the bus must read 8'h00.
   task automatic host_read(input string nm);
      logic [7:0] exp;
      exp = 8'h00;
      if (rx_exp.size() != 0) exp = rx_exp.pop_front();
      @(posedge clk);
      bus_read = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check8(nm, bus_data, exp);
      bus_read = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
   endtask

   // With bus_read low the bridge must leave the bus to the host.
   task automatic check_released(input string nm);
      host_drv = 8'h96;
      host_oe  = 1'b1;
      #1;
      check8(nm, bus_data, 8'h96);
      host_oe  = 1'b0;
   endtask

   task automatic send_serial(input logic [7:0] b, input logic stop);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rxd = fr[i];
         repeat (CPB) @(posedge clk);
      end
      uart_rxd = 1'b1;
      repeat (20) @(posedge clk);
   endtask

   task automatic pulse_err_clr();
      @(posedge clk);
      err_clr = 1'b1;
      repeat (4) @(posedge clk);
      err_clr = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_tx_done(input int budget);
      int k;
      k = 0;
      while ((tx_exp.size() != 0 || mon_busy) && k < budget) begin
         @(posedge clk);
         k++;
      end
      n_vec++;
      if (k >= budget) begin
         n_err++;
         $display("FAIL tx_done_timeout: %0d frames still pending after %0d cycles, expected 0",
                  tx_exp.size(), budget);
      end
   endtask

   // TX monitor: on each falling edge of uart_txd, compare all 160 cycles of
   // the frame against the ideal 8N1 waveform of the expected byte.
   initial begin : tx_monitor
      logic       prev;
      logic       known;
      logic       ok;
      logic       aborted;
      logic [7:0] exp_b;
      logic [7:0] got_b;
      logic [9:0] fr;
      int         start_cyc;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev = 1'b1;
         end else if (prev && !uart_txd) begin
            mon_busy  = 1'b1;
            start_cyc = cyc;
            known     = (tx_exp.size() != 0);
            exp_b     = 8'h00;
            if (known) exp_b = tx_exp.pop_front();
            if (gap_chk) begin
               if (gap_valid) check_int("tx_back_to_back_gap", start_cyc - last_start, FRAME);
               last_start = start_cyc;
               gap_valid  = 1'b1;
            end
            fr      = {1'b1, exp_b, 1'b0};
            ok      = 1'b1;
            aborted = 1'b0;
            got_b   = 8'h00;
            for (int i = 0; i < FRAME; i++) begin
               if (i > 0) @(negedge clk);
               if (!reset_n) begin
                  aborted = 1'b1;
                  break;
               end
               if (uart_txd !== fr[i / CPB]) ok = 1'b0;
               if ((i % CPB) == CPB / 2 && i >= CPB && i < 9 * CPB) got_b[i / CPB - 1] = uart_txd;
            end
            if (!aborted) begin
               frames_seen++;
               n_vec++;
               if (!known) begin
                  n_err++;
                  $display("FAIL tx_frame: got unexpected frame %h, expected no frame", got_b);
               end else if (!ok) begin
                  n_err++;
                  $display("FAIL tx_frame: got frame decoding to %h, expected exact 8N1 frame of %h",
                           got_b, exp_b);
               end
            end
            prev     = uart_txd;
            mon_busy = 1'b0;
         end else begin
            prev = uart_txd;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

   typedef struct {
      logic [7:0] tx_byte;
      logic [7:0] rx_byte;
      logic       rx_stop;
      logic       exp_avail;
      logic       exp_ferr;
   } vec_t;

   initial begin : main
      vec_t       vt [5];
      logic [7:0] b;
      int         fs0;

      vt[0] = '{8'hA5, 8'h3C, 1'b1, 1'b1, 1'b0};
      vt[1] = '{8'h00, 8'hFF, 1'b1, 1'b1, 1'b0};
      vt[2] = '{8'hFF, 8'h00, 1'b1, 1'b1, 1'b0};
      vt[3] = '{8'h5A, 8'h81, 1'b0, 1'b0, 1'b1};
      vt[4] = '{8'h80, 8'h7E, 1'b1, 1'b1, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check1("reset_uart_txd",   uart_txd,   1'b1);
      check1("reset_tx_full",    tx_full,    1'b0);
      check1("reset_rx_avail",   rx_avail,   1'b0);
      check1("reset_rx_overrun", rx_overrun, 1'b0);
      check1("reset_frame_err",  frame_err,  1'b0);
      check_released("reset_bus_released");
      reset_n = 1'b1;
      repeat (3) @(posedge clk);

      // Table: a TX byte and an RX frame per record, full duplex
      for (int v = 0; v < 5; v++) begin
         host_load(vt[v].tx_byte, 1'b1);
         if (vt[v].rx_stop) rx_exp.push_back(vt[v].rx_byte);
         send_serial(vt[v].rx_byte, vt[v].rx_stop);
         @(negedge clk);
         check1($sformatf("vec%0d_rx_avail", v), rx_avail, vt[v].exp_avail);
         check1($sformatf("vec%0d_frame_err", v), frame_err, vt[v].exp_ferr);
         if (vt[v].exp_avail) begin
            host_read($sformatf("vec%0d_read_data", v));
            check1($sformatf("vec%0d_rx_avail_after_read", v), rx_avail, 1'b0);
         end
         if (vt[v].exp_ferr) begin
            pulse_err_clr();
            check1($sformatf("vec%0d_frame_err_cleared", v), frame_err, 1'b0);
         end
         check_released($sformatf("vec%0d_bus_released", v));
         wait_tx_done(4 * FRAME);
      end

      // Nine quick loads: FIFO fills, tenth is dropped, frames back to back
      gap_chk   = 1'b1;
      gap_valid = 1'b0;
      fs0       = frames_seen;
      for (int k = 1; k <= 9; k++) host_load(8'(k), 1'b1);
      @(negedge clk);
      check1("tx_full_after_9", tx_full, 1'b1);
      host_load(8'hEE, 1'b0);
      @(negedge clk);
      check1("tx_full_after_drop", tx_full, 1'b1);
      wait_tx_done(12 * FRAME);
      repeat (2 * FRAME) @(posedge clk);
      check_int("tx_frame_count", frames_seen - fs0, 9);
      gap_chk = 1'b0;
      @(negedge clk);
      check1("tx_full_drained", tx_full, 1'b0);

      // One-cycle low glitch on the serial line
      @(posedge clk);
      uart_rxd = 1'b0;
      @(posedge clk);
      uart_rxd = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      check1("glitch_rx_avail",  rx_avail,  1'b0);
      check1("glitch_frame_err", frame_err, 1'b0);

      // Nine RX frames with no reads: eight stored, then overrun
      for (int k = 0; k < 9; k++) begin
         b = 8'(16 + k * 7);
         if (k < 8) rx_exp.push_back(b);
         send_serial(b, 1'b1);
         if (k == 7) begin
            @(negedge clk);
            check1("overrun_before_9th", rx_overrun, 1'b0);
         end
      end
      @(negedge clk);
      check1("overrun_after_9th", rx_overrun, 1'b1);
      check1("overrun_rx_avail",  rx_avail,   1'b1);
      for (int k = 0; k < 8; k++) host_read($sformatf("overrun_read%0d", k));
      check1("overrun_drained_rx_avail", rx_avail, 1'b0);
      host_read("read_empty_returns_zero");
      check1("overrun_sticky", rx_overrun, 1'b1);

      // Reset in the middle of a transmitted frame
      rx_exp.push_back(8'h11);
      send_serial(8'h11, 1'b1);
      @(negedge clk);
      check1("pre_reset_rx_avail", rx_avail, 1'b1);
      host_load(8'hC3, 1'b1);
      repeat (40) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check1("midframe_reset_uart_txd",   uart_txd,   1'b1);
      check1("midframe_reset_tx_full",    tx_full,    1'b0);
      check1("midframe_reset_rx_avail",   rx_avail,   1'b0);
      check1("midframe_reset_rx_overrun", rx_overrun, 1'b0);
      check1("midframe_reset_frame_err",  frame_err,  1'b0);
      tx_exp.delete();
      rx_exp.delete();
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      host_load(8'h4B, 1'b1);
      wait_tx_done(4 * FRAME);
      host_read("post_reset_read_empty");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
